// File: rtl/audio_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : audio_capture_ctrl
// Description : Record/playback sequencer for the PDM recorder datapath with
//               word counting, overrun/timeout detection and sticky status.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_capture_ctrl #(
    parameter int LEN_W   = 10,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_play,
    input  logic             word_push,
    input  logic             word_pop,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             rec_en,
    output logic             play_en,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             timeout,
    output logic [LEN_W-1:0] word_cnt,
    output logic [2:0]       state
);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [SET_W-1:0] c_settle_last = SET_W'(SETTLE - 1);
    localparam logic [GAP_W-1:0] c_gap_last    = GAP_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] c_cnt_max     = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RECORD = 3'd2,
        S_PLAY   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             play_cfg_q, play_cfg_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;
    logic             rec_en_q, play_en_q, busy_q;
    logic [LEN_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        play_cfg_d = play_cfg_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        gap_d      = gap_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        to_d       = to_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    len_d      = cfg_len;
                    play_cfg_d = cfg_play;
                    done_d     = 1'b0;
                    ovr_d      = 1'b0;
                    to_d       = 1'b0;
                    cnt_d      = '0;
                    settle_d   = '0;
                    gap_d      = '0;
                    state_d    = (cfg_len == '0) ? S_FINISH : S_ARM;
                end
            end
            S_ARM: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else begin
                    // Counter parks at its last value while waiting for an empty FIFO
                    if (settle_q != c_settle_last)
                        settle_d = settle_q + SET_W'(1);
                    if (settle_q == c_settle_last && fifo_empty) begin
                        state_d = S_RECORD;
                        gap_d   = '0;
                    end
                end
            end
            S_RECORD: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (word_push) begin
                        cnt_d = w_cnt_inc;
                        gap_d = '0;
                    end else if (gap_q != c_gap_last) begin
                        gap_d = gap_q + GAP_W'(1);
                    end

                    if (word_push && w_cnt_inc == len_q) begin
                        state_d = play_cfg_q ? S_PLAY : S_FINISH;
                    end else if (fifo_full && cnt_q < len_q) begin
                        ovr_d   = 1'b1;
                        state_d = S_FINISH;
                    end else if (!word_push && gap_q == c_gap_last) begin
                        to_d    = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_PLAY: begin
                if (cmd_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (word_pop && cnt_q != '0)
                        cnt_d = cnt_q - LEN_W'(1);
                    if ((fifo_empty && !word_pop) || cnt_q == '0)
                        state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (state_d == S_FINISH)
            done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            play_cfg_q <= 1'b0;
            cnt_q      <= '0;
            settle_q   <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            to_q       <= 1'b0;
            rec_en_q   <= 1'b0;
            play_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            play_cfg_q <= play_cfg_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            to_q       <= to_d;
            rec_en_q   <= (state_d == S_RECORD);
            play_en_q  <= (state_d == S_PLAY);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign rec_en   = rec_en_q;
    assign play_en  = play_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = ovr_q;
    assign timeout  = to_q;
    assign word_cnt = cnt_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_capture_ctrl
// Description : Randomized scoreboard bench for audio_capture_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_capture_ctrl;
    localparam int LEN_W   = 10;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 32;

    logic             clk = 1'b0;
    logic             rst, cmd_start, cmd_abort, cfg_play;
    logic             word_push, word_pop, fifo_full, fifo_empty;
    logic [LEN_W-1:0] cfg_len;
    logic             rec_en, play_en, busy, done, overrun, timeout;
    logic [LEN_W-1:0] word_cnt;
    logic [2:0]       state;

    always #5 clk = ~clk;

    audio_capture_ctrl #(.LEN_W(LEN_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_len(cfg_len), .cfg_play(cfg_play), .word_push(word_push),
        .word_pop(word_pop), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rec_en(rec_en), .play_en(play_en), .busy(busy), .done(done),
        .overrun(overrun), .timeout(timeout), .word_cnt(word_cnt), .state(state)
    );

    // Expected outcome of one operation, from start command back to idle
    typedef struct {
        int done;
        int ovr;
        int to;
        int cnt;
        int arm;
        int fin;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: per-operation statistics, compared when busy falls
    int         arm_c = 0, fin_c = 0, bad_c = 0, since = 0, lat = -1;
    logic       prev_busy = 1'b0, prev_to = 1'b0;
    logic [2:0] prev_state = 3'd0;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            arm_c = 0; fin_c = 0; bad_c = 0; lat = -1;
        end
        if (state == 3'd1) arm_c++;
        if (state == 3'd4) fin_c++;
        if (rec_en !== (state == 3'd2) || play_en !== (state == 3'd3) || busy !== (state != 3'd0))
            bad_c++;
        since++;
        if (state == 3'd2 && prev_state != 3'd2) since = 0;
        if (state == 3'd2 && word_push) since = -1;
        if (timeout && !prev_to) lat = since;

        if (mon_en && !busy && prev_busy) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL completion: got unexpected completion, expected none queued");
            end else begin
                e = exp_q.pop_front();
                check("end_state",   32'(state),    0);
                check("done",        32'(done),     32'(e.done));
                check("overrun",     32'(overrun),  32'(e.ovr));
                check("timeout",     32'(timeout),  32'(e.to));
                check("word_cnt",    32'(word_cnt), 32'(e.cnt));
                check("arm_cycles",  32'(arm_c),    32'(e.arm));
                check("finish_cyc",  32'(fin_c),    32'(e.fin));
                check("enable_bad",  32'(bad_c),    0);
                if (e.to != 0) check("timeout_lat", 32'(lat), 32'(TIMEOUT));
            end
        end
        prev_busy  = busy;
        prev_to    = timeout;
        prev_state = state;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin tick(); n++; end
        check(name, 32'(busy), 0);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state !== s && n < 100) begin tick(); n++; end
        check(name, 32'(state), 32'(s));
    endtask

    task automatic rec_gap();
        int g = $urandom_range(0, 3);
        repeat (g) begin word_pop = ($urandom_range(0, 1) == 1); tick(); end
        word_pop = 1'b0;
    endtask

    // kind: 0 record, 1 record+play, 2 overrun, 3 timeout, 4 abort, 5 zero length
    task automatic run_op(input int kind);
        int   L, E, k, m, n_push, g;
        exp_t ex;
        L = (kind == 5) ? 0 : $urandom_range(1, 8);
        E = $urandom_range(0, 24);
        k = (L > 0) ? $urandom_range(0, L - 1) : 0;
        m = (kind == 1) ? (($urandom_range(0, 1) == 1) ? L : $urandom_range(1, L)) : 0;

        ex.done = (kind == 4) ? 0 : 1;
        ex.ovr  = (kind == 2) ? 1 : 0;
        ex.to   = (kind == 3) ? 1 : 0;
        ex.fin  = (kind == 4) ? 0 : 1;
        ex.arm  = (L == 0) ? 0 : ((E + 1 > SETTLE) ? E + 1 : SETTLE);
        case (kind)
            0:       ex.cnt = L;
            1:       ex.cnt = L - m;
            5:       ex.cnt = 0;
            default: ex.cnt = k;
        endcase
        exp_q.push_back(ex);

        cfg_len    = LEN_W'(L);
        cfg_play   = (kind == 1);
        fifo_empty = (E == 0);
        cmd_start  = 1'b1;
        tick();
        cmd_start = 1'b0;
        cfg_len   = LEN_W'($urandom);
        cfg_play  = 1'($urandom);

        if (L != 0) begin
            for (int i = 0; i < 200 && state == 3'd1; i++) begin
                fifo_empty = (i >= E);
                word_push  = ($urandom_range(0, 3) == 0);
                tick();
            end
            word_push  = 1'b0;
            fifo_empty = 1'b0;

            n_push = (kind == 0 || kind == 1) ? L : k;
            for (int j = 0; j < n_push; j++) begin
                rec_gap();
                word_push = 1'b1; tick(); word_push = 1'b0;
            end

            case (kind)
                1: begin
                    wait_state(3'd3, "play_entry");
                    for (int j = 0; j < m; j++) begin
                        g = $urandom_range(0, 3);
                        repeat (g) begin
                            word_push = ($urandom_range(0, 1) == 1);
                            cmd_start = ($urandom_range(0, 1) == 1);
                            cfg_len   = LEN_W'($urandom_range(1, 1023));
                            tick();
                        end
                        word_push = 1'b0; cmd_start = 1'b0;
                        word_pop = 1'b1; tick(); word_pop = 1'b0;
                    end
                    fifo_empty = 1'b1;
                end
                2: begin
                    rec_gap();
                    fifo_full = 1'b1; tick(); fifo_full = 1'b0;
                end
                4: begin
                    rec_gap();
                    word_push = 1'b1; cmd_abort = 1'b1; tick();
                    word_push = 1'b0; cmd_abort = 1'b0;
                end
                default: ;
            endcase
        end
        wait_idle("op_idle");
        fifo_full = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cfg_play = 1'b0;
        word_push = 1'b0; word_pop = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        cfg_len = '0;
        repeat (3) tick();
        check("reset_outputs", 32'({state, rec_en, play_en, busy, done, overrun, timeout}), 0);
        check("reset_cnt", 32'(word_cnt), 0);
        rst = 1'b0;

        // Reset in the middle of RECORD with five words counted
        cfg_len = LEN_W'(8); cmd_start = 1'b1; tick(); cmd_start = 1'b0;
        wait_state(3'd2, "rec_entry");
        repeat (5) begin word_push = 1'b1; tick(); word_push = 1'b0; tick(); end
        check("pre_reset_cnt", 32'(word_cnt), 5);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_state",  32'(state),  0);
        check("midrst_rec_en", 32'(rec_en), 0);
        check("midrst_cnt",    32'(word_cnt), 0);
        check("midrst_flags",  32'({busy, done, overrun, timeout}), 0);
        tick();

        mon_en = 1'b1;
        for (int n = 0; n < 40; n++)
            run_op((n < 6) ? n : $urandom_range(0, 5));

        // Reset must also clear sticky flags left in IDLE
        run_op(3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("idle_rst_flags", 32'({busy, done, overrun, timeout}), 0);
        check("idle_rst_cnt",   32'(word_cnt), 0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_capture_ctrl.md
Name: audio_capture_ctrl

Overview:
Sequencer for the PDM microphone recorder datapath: microphone front end, FIFO and J1 peripheral.
- Runs one record phase, then an optional playback phase, from a single start command.
- Counts FIFO words, detects overrun and stalled-microphone timeout, and reports sticky status to the J1 peripheral register file.
- Sits between the peripheral address decoder (commands and config) and the recorder/FIFO (enables and strobes).

Parameters:
LEN_W, 10, width of word length and word counter
SETTLE, 16, ARM cycles with enables low before recording (mic start-up and FIFO settle)
TIMEOUT, 4096, max clk cycles between word_push strobes during RECORD

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
cmd_start  in  1  one-cycle pulse; start a capture
cmd_abort  in  1  one-cycle pulse; abandon current operation
cfg_len  in  LEN_W  number of words to record; sampled on accepted cmd_start
cfg_play  in  1  1 = play back after recording; sampled on accepted cmd_start
word_push  in  1  recorder wrote one word into FIFO (one-cycle strobe)
word_pop  in  1  playback consumed one word from FIFO (one-cycle strobe)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
rec_en  out  1  recorder enable (level)
play_en  out  1  playback enable (level)
busy  out  1  1 in any state except IDLE
done  out  1  sticky; set on normal completion; cleared by accepted cmd_start
overrun  out  1  sticky; FIFO full during RECORD before length reached
timeout  out  1  sticky; no word_push for TIMEOUT cycles in RECORD
word_cnt  out  LEN_W  words recorded, decremented during playback
state  out  3  current state code for debug readback

Behaviour:
- All outputs registered. A transition decided in cycle N is visible in cycle N+1.
- Reset (rst=1 at a clk edge) has absolute priority, including mid-operation:
  - state=IDLE.
  - rec_en, play_en, busy, done, overrun and timeout all 0.
  - word_cnt=0; internal counters 0.
- State codes: IDLE=0, ARM=1, RECORD=2, PLAY=3, FINISH=4. Codes 5-7 are unreachable and return to IDLE.
- cmd_abort in any non-IDLE state:
  - Next state is IDLE; rec_en and play_en drop the next cycle.
  - done is not set. word_cnt and sticky flags hold.
  - Abort wins over every other event in the same cycle.
- IDLE:
  - Enables are 0.
  - cmd_start=1 and cmd_abort=0: latch cfg_len and cfg_play; clear done, overrun and timeout; word_cnt=0; settle counter=0; go to ARM.
  - cfg_len=0: go directly to FINISH instead (done=1, word_cnt=0).
- ARM:
  - Enables are 0; the settle counter increments each cycle.
  - Leave for RECORD when the counter reaches SETTLE-1 and fifo_empty=1. This gives exactly SETTLE ARM cycles if the FIFO is already empty.
  - If the FIFO is not empty, remain in ARM until it is.
- RECORD:
  - rec_en=1. Each word_push increments word_cnt (saturating at 2^LEN_W-1) and clears the gap counter. Otherwise the gap counter increments.
  - word_push that makes word_cnt equal to the latched length: go to PLAY if latched play=1, else FINISH. rec_en is low from the next cycle.
  - fifo_full=1 while word_cnt < latched length: overrun=1, go to FINISH. done is still set; software checks overrun.
  - Gap counter reaches TIMEOUT-1: timeout=1, go to FINISH.
  - Priority when events coincide: abort > length reached > overrun > timeout.
- PLAY:
  - play_en=1. Each word_pop decrements word_cnt, never below 0.
  - Exit to FINISH when fifo_empty=1 and no word_pop in the same cycle, or when word_cnt is 0.
- FINISH: one cycle; done=1; enables 0; next state is IDLE. busy is 1 in FINISH and 0 from IDLE on.
- cmd_start while busy=1 is ignored and flags are unchanged.
- word_push outside RECORD and word_pop outside PLAY are ignored.

Test Plan:
- Reset mid-RECORD with word_cnt=5, rst high 1 cycle -> next cycle state=0, rec_en=0, word_cnt=0, all flags 0.
- Nominal capture: cfg_len=4, cfg_play=0, fifo_empty=1, start pulse -> ARM for 16 cycles, rec_en=1; after 4 word_push -> word_cnt=4, FINISH 1 cycle, done=1, busy=0.
- Capture with playback: cfg_len=3, cfg_play=1, 3 pushes then 3 pops with fifo_empty rising after the last pop -> play_en high throughout PLAY, word_cnt 3->0, done=1.
- Overrun: cfg_len=8, fifo_full=1 after the 2nd push -> overrun=1, word_cnt=2, rec_en low next cycle, done=1.
- Timeout: TIMEOUT=32, cfg_len=4, one push then silence -> timeout=1 exactly 32 cycles after that push, word_cnt=1.
- Abort and edge cases:
  - cmd_abort and word_push in the same RECORD cycle -> state=0, word_cnt unchanged, done=0.
  - cmd_start with cfg_len=0 -> FINISH then IDLE, done=1.
  - cmd_start during PLAY -> ignored.
